// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bit counter width; sized to hold WIDTH so the count range always fits.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bo = borrow out.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b, bin (inputs); d (difference bit), bo (borrow out).
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bin;
  // Borrow when b exceeds a, or when they are equal and a borrow is pending.
  assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, diff = a - b - bin modulo 2^WIDTH, LSB first.
// Latency: done pulses in cycle WIDTH+1 after the start edge; one result per WIDTH+1 cycles.
// Backpressure: none; start is accepted only in IDLE or DONE and ignored while busy.
// Ports: clk, rst_n (async active-low); start/a/b/bin request; diff/bout registered
// result; busy high during shifting; done one-cycle result strobe; ovf (signed
// overflow) exists only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             fs_d, fs_bo;
  logic [WIDTH-1:0] res_shift;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .bin (br_q),
    .d   (fs_d),
    .bo  (fs_bo)
  );

  // Result register with the new difference bit entering at the MSB; after
  // WIDTH steps the first (LSB) bit has reached position 0.
  always_comb begin
    res_shift            = res_sh_q >> 1;
    res_shift[WIDTH-1]   = fs_d;
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        br_d     = fs_bo;
        res_sh_d = res_shift;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Publish only on the final step so diff/bout hold the previous
          // result while a new operation is shifting.
          diff_d  = res_shift;
          bout_d  = fs_bo;
`ifdef SERIAL_SUB_OVF_EN
          // Operand MSBs sit at bit 0 of the shift registers this step.
          ovf_d   = (a_sh_q[0] ^ b_sh_q[0]) & (a_sh_q[0] ^ fs_d);
`endif
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised bit-serial subtractor computing `diff = a - b - bin` over `WIDTH` bits, one bit per clock, LSB first. Successor to the combinational half-subtractor cell: adds operand width, borrow-in/borrow-out chaining and a start/busy/done handshake. Used wherever area matters more than latency, such as the datapath of multi-cycle arithmetic units.

## Interface

Parameters:
- `WIDTH`, default 8. Operand and result width; legal range ≥ 1.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new subtraction; sampled only when not busy.
- `a`  in  WIDTH  minuend; sampled with `start`.
- `b`  in  WIDTH  subtrahend; sampled with `start`.
- `bin`  in  1  borrow-in; sampled with `start`.
- `diff`  out  WIDTH  result; registered.
- `bout`  out  1  borrow-out of the MSB; registered.
- `busy`  out  1  high while bits are being processed.
- `done`  out  1  one-cycle pulse when `diff`/`bout` become valid.
- `ovf`  out  1  signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation

- FSM states: IDLE, SHIFT, DONE.
  - IDLE: when `start`=1, load `a`, `b` into shift registers, load `bin` into the borrow flop, clear the bit counter, then go to SHIFT.
  - SHIFT: each cycle, run one full-subtractor step on the LSB of each operand and the borrow flop.
    - `d = a0 ^ b0 ^ br`; `br' = (~a0 & b0) | (~(a0 ^ b0) & br)`.
    - Shift `d` into the MSB of the result register; shift the operands right.
    - After WIDTH steps, go to DONE.
  - DONE: `done`=1 for one cycle; `bout` = final borrow. Next state is SHIFT if `start`=1 (new operands loaded that cycle), else IDLE.
- `start` is ignored while in SHIFT; `a`, `b` and `bin` may change freely there.
- `diff` and `bout` hold their last values until the final SHIFT step of the next operation completes.
- Bit counter width is `$clog2(WIDTH+1)`. For WIDTH=1 the SHIFT state lasts exactly one cycle.
- Arithmetic is modulo 2^WIDTH; `bout`=1 exactly when `a < b + bin` (unsigned).
- Reset (asynchronous, any state, including mid-SHIFT):
  - FSM goes to IDLE.
  - `diff`=0, `bout`=0, `busy`=0, `done`=0, `ovf`=0.
  - Operation in flight is discarded.

## Timing

- `start` sampled at edge 0.
- `busy`=1 during cycles 1..WIDTH.
- `done`=1 and result valid in cycle WIDTH+1.
- Latency is WIDTH+1 cycles from the start edge to `done`.
- Back-to-back throughput: one result per WIDTH+1 cycles, with `start` held or re-asserted during DONE.
- `busy` and `done` are never high together.
- Release of `rst_n` is synchronised by the integrating level; the block needs no extra cycles after deassertion.

## Configuration

- `SERIAL_SUB_OVF_EN` defined:
  - Adds the `ovf` output.
  - `ovf` = `a[MSB] ^ b[MSB]` & (`a[MSB] ^ diff[MSB]`), computed in the final SHIFT step using the MSB operand bits captured that step.
  - `ovf` is registered, updated alongside `bout`, and holds until the next result.
- `SERIAL_SUB_OVF_EN` undefined:
  - No `ovf` port and no associated logic.
  - All other behaviour is identical.

## Structure

- Package `serial_sub_pkg` holds:
  - FSM state enum (IDLE, SHIFT, DONE).
  - The counter-width function/constant.
- Sub-module `full_subtractor` (inputs `a`, `b`, `bin`; outputs `d`, `bo`; combinational) is instantiated once in the SHIFT datapath.
- Top-level `serial_subtractor` holds the FSM, shift registers, counter, borrow flop and output registers.

## Test plan

- WIDTH=8: a=0x05, b=0x03, bin=0 → after 9 cycles `done` pulses with diff=0x02, bout=0.
- WIDTH=8: a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1; then a=0x00, b=0x00, bin=1 started in the DONE cycle → diff=0xFF, bout=1 exactly 9 cycles later.
- WIDTH=1: all 8 combinations of a, b, bin → diff/bout match the full-subtractor truth table, each with a 2-cycle latency.
- WIDTH=8: `start` pulsed with a=0x10 at cycle 3 of a busy 0x20-0x01 operation → ignored; result diff=0x1F; `busy` and `done` never overlap.
- WIDTH=8: `rst_n` low at cycle 4 of an operation → all outputs 0 immediately, FSM in IDLE; a fresh 0x09-0x04 afterwards → diff=0x05.
- With `SERIAL_SUB_OVF_EN`, WIDTH=8: 0x80-0x01 → diff=0x7F, ovf=1; 0x7F-0xFF → diff=0x80, ovf=1; 0x05-0x03 → ovf=0.
